// File: rtl/burst_ram_if.sv
// Request/response bundle for burst_ram: request strobe with burst
// descriptor and write data in, ready/read data/done back out.
interface burst_ram_if #(
  parameter int ADDR_BITS  = 5,
  parameter int BURST_BITS = 3,
  parameter int RAM_BITS   = 8
);
  logic                  REQ;
  logic                  REQ_WRITE;
  logic [ADDR_BITS-1:0]  REQ_ADDR;
  logic [BURST_BITS-1:0] REQ_LEN;
  logic [RAM_BITS-1:0]   DATA_IN;
  logic                  READY;
  logic [RAM_BITS-1:0]   DATA_OUT;
  logic                  DATA_OUT_VALID;
  logic                  DONE;

  modport master (
    output REQ, REQ_WRITE, REQ_ADDR, REQ_LEN, DATA_IN,
    input  READY, DATA_OUT, DATA_OUT_VALID, DONE
  );

  modport slave (
    input  REQ, REQ_WRITE, REQ_ADDR, REQ_LEN, DATA_IN,
    output READY, DATA_OUT, DATA_OUT_VALID, DONE
  );
endinterface

// File: rtl/burst_ram.sv
// Single-port burst RAM. After reset the array is zeroed one word per
// cycle (CLEAR), then bursts of up to 2**BURST_BITS words are served.
// Write bursts store the first word on the accepting edge; read bursts
// return registered data starting the second cycle after acceptance.
module burst_ram #(
  parameter int RAM_LOCATIONS = 32,
  parameter int RAM_BITS      = 8,
  parameter int ADDR_BITS     = 5,
  parameter int BURST_BITS    = 3
) (
  input  logic       clk,
  input  logic       RESET_N,
  burst_ram_if.slave bus
);

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, READ} state_t;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  clr_cnt;
  logic [ADDR_BITS-1:0]  addr;     // next burst address
  logic [BURST_BITS-1:0] rem;      // words left after the current one
  logic [RAM_BITS-1:0]   mem [RAM_LOCATIONS];
  logic [RAM_BITS-1:0]   dout;
  logic                  dout_vld;
  logic                  done;

  logic                  accept;
  logic                  we;
  logic [ADDR_BITS-1:0]  waddr;
  logic [RAM_BITS-1:0]   wdata;

  assign bus.READY          = (state == IDLE);
  assign bus.DATA_OUT       = dout;
  assign bus.DATA_OUT_VALID = dout_vld;
  assign bus.DONE           = done;

  // State register; reset restarts the zero-fill sweep.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) state <= CLEAR;
    else          state <= state_nxt;
  end

  // Next state, acceptance and the single memory write port.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    we        = 1'b0;
    waddr     = addr;
    wdata     = bus.DATA_IN;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = '0;
        if (clr_cnt == ADDR_BITS'(RAM_LOCATIONS - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (bus.REQ) begin
          accept = 1'b1;
          if (bus.REQ_WRITE) begin
            // first word lands on the accepting edge
            we    = 1'b1;
            waddr = bus.REQ_ADDR;
            if (bus.REQ_LEN != '0) state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WRITE: begin
        we = 1'b1;
        if (rem == BURST_BITS'(1)) state_nxt = IDLE;
      end
      READ: begin
        if (rem == '0) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Memory array; zero-fill comes through the same write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Burst address/length tracking, registered read data and done pulse.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      clr_cnt  <= '0;
      addr     <= '0;
      rem      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      done     <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      done     <= 1'b0;
      case (state)
        CLEAR: clr_cnt <= clr_cnt + ADDR_BITS'(1);
        IDLE: begin
          if (accept) begin
            // writes already consumed the start address this edge
            addr <= bus.REQ_ADDR + ADDR_BITS'(bus.REQ_WRITE);
            rem  <= bus.REQ_LEN;
            done <= bus.REQ_WRITE && (bus.REQ_LEN == '0);
          end
        end
        WRITE: begin
          addr <= addr + ADDR_BITS'(1);
          rem  <= rem - BURST_BITS'(1);
          done <= (rem == BURST_BITS'(1));
        end
        READ: begin
          dout     <= mem[addr];
          dout_vld <= 1'b1;
          addr     <= addr + ADDR_BITS'(1);
          rem      <= rem - BURST_BITS'(1);
          done     <= (rem == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 The block SHALL have parameter RAM_LOCATIONS, default 32, number of words; it SHALL equal 2**ADDR_BITS.
REQ-002 The block SHALL have parameter RAM_BITS, default 8, word width.
REQ-003 The block SHALL have parameter ADDR_BITS, default 5, address width.
REQ-004 The block SHALL have parameter BURST_BITS, default 3, burst-length field width (max burst 2**BURST_BITS words).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port REQ, input, 1, request strobe.
REQ-008 The block SHALL have port REQ_WRITE, input, 1, 1 = write burst, 0 = read burst.
REQ-009 The block SHALL have port REQ_ADDR, input, ADDR_BITS, burst start address.
REQ-010 The block SHALL have port REQ_LEN, input, BURST_BITS, burst length minus one.
REQ-011 The block SHALL have port DATA_IN, input, RAM_BITS, write data, one word per cycle.
REQ-012 The block SHALL have port READY, output, 1, high when a request can be accepted.
REQ-013 The block SHALL have port DATA_OUT, output, RAM_BITS, registered read data.
REQ-014 The block SHALL have port DATA_OUT_VALID, output, 1, DATA_OUT holds a burst word this cycle.
REQ-015 The block SHALL have port DONE, output, 1, one-cycle pulse marking burst completion.

Function
REQ-016 The FSM SHALL have states CLEAR, IDLE, WRITE and READ; READY SHALL be high only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where REQ=1 and READY=1; REQ while READY=0 SHALL be ignored with no side effects.
REQ-018 On write acceptance, DATA_IN SHALL be written to REQ_ADDR at that same edge; if REQ_LEN>0, the FSM SHALL enter WRITE for REQ_LEN cycles, writing DATA_IN to address start+k at edge k (k=1..REQ_LEN).
REQ-019 DONE SHALL be high for the one cycle following the edge that writes the last burst word, including REQ_LEN=0.
REQ-020 On read acceptance, the FSM SHALL enter READ for REQ_LEN+1 cycles; at edge k (k=1..REQ_LEN+1), DATA_OUT SHALL load mem[start+k-1] and DATA_OUT_VALID SHALL be high in the following cycle.
REQ-021 DONE SHALL coincide with the last DATA_OUT_VALID cycle of a read burst; the FSM SHALL be in IDLE, with READY=1, during that same cycle.
REQ-022 Burst addresses SHALL increment modulo RAM_LOCATIONS (address RAM_LOCATIONS-1 wraps to 0).
REQ-023 DATA_OUT SHALL hold its last value while DATA_OUT_VALID=0; DATA_OUT_VALID and DONE SHALL be 0 in every cycle not named above.
REQ-024 REQ_ADDR, REQ_LEN and REQ_WRITE SHALL be latched at acceptance; later changes SHALL not affect the burst in flight.
REQ-025 In CLEAR, one word per cycle SHALL be written to 0 in ascending addresses 0..RAM_LOCATIONS-1, then the FSM SHALL enter IDLE.

Reset
REQ-026 RESET_N=0 SHALL immediately force state CLEAR, the clear counter to 0, READY=0, DATA_OUT=0, DATA_OUT_VALID=0 and DONE=0.
REQ-027 After RESET_N deasserts, READY SHALL rise exactly RAM_LOCATIONS cycles later, with all memory words equal to 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst without a DONE pulse; partial writes are overwritten by CLEAR.

Verification
REQ-029 The bench SHALL cover: reset release -> READY low 32 cycles then high; read addr 7 LEN 0 -> DATA_OUT=0x00 with VALID and DONE one cycle.
REQ-030 The bench SHALL cover: write addr 4 LEN 2 data 0x11,0x22,0x33 -> READY low 2 cycles, DONE once; read addr 4 LEN 2 -> 0x11,0x22,0x33 on 3 consecutive VALID cycles, DONE with 0x33.
REQ-031 The bench SHALL cover: write addr 30 LEN 3 data 0xA0..0xA3 -> mem[30]=0xA0, mem[31]=0xA1, mem[0]=0xA2, mem[1]=0xA3, confirmed by read addr 30 LEN 3.
REQ-032 The bench SHALL cover: write 0xAA to addr 31 LEN 0, then read addr 31 -> DATA_OUT=0xAA valid in the second cycle after read acceptance.
REQ-033 The bench SHALL cover: REQ write addr 0 data 0x55 held high during a LEN 7 read burst -> ignored, mem[0] unchanged, eight VALID cycles.
REQ-034 The bench SHALL cover: RESET_N pulsed low during a write burst to addr 31 -> outputs 0 at once, no DONE, after CLEAR mem[31]=0x00.
